// File: rtl/pedestrian_signal_ctrl_pkg.sv
// Shared semaphore one-hot codes and pedestrian head state encoding for the
// pedestrian crossing controller and its consumers.
package pedestrian_signal_ctrl_pkg;

  localparam logic [3:0] SEM_OFF    = 4'b0001;
  localparam logic [3:0] SEM_RED    = 4'b0010;
  localparam logic [3:0] SEM_YELLOW = 4'b0100;
  localparam logic [3:0] SEM_GREEN  = 4'b1000;

  typedef enum logic [3:0] {
    PED_DARK      = 4'b0001,
    PED_DONT_WALK = 4'b0010,
    PED_WALK      = 4'b0100,
    PED_FLASH     = 4'b1000
  } ped_state_e;

  // True only for a legal, powered semaphore code (OFF, 0000 and multi-hot excluded).
  function automatic logic sem_is_active(input logic [3:0] s);
    return (s == SEM_RED) || (s == SEM_YELLOW) || (s == SEM_GREEN);
  endfunction

endpackage

// File: rtl/pedestrian_signal_ctrl_button_sync_edge.sv
// Two-flop synchronizer for the raw push-button followed by a rising-edge
// detector; a held button yields a single one-cycle rise pulse.
module button_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/pedestrian_signal_ctrl.sv
// Pedestrian WALK/DONT_WALK head controller slaved to the vehicle semaphore:
// grants a timed walk + flash phase on red entry when a request is latched.
module pedestrian_signal_ctrl
  import pedestrian_signal_ctrl_pkg::*;
#(
  parameter int unsigned WALK_CYCLES  = 8,
  parameter int unsigned FLASH_CYCLES = 6,
  parameter int unsigned CNT_W        = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       sem_state,
  input  logic             ped_button,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending,
  output logic [3:0]       ped_state
);

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  ped_state_e       r_state;
  ped_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_blink;
  logic             w_blink_nxt;
  logic             r_req;
  logic             w_req_nxt;
  logic [3:0]       r_sem_prev;

  logic             w_rise;
  logic             w_sem_red;
  logic             w_red_entry;
  logic             w_override;
  logic             w_grant;

  button_sync_edge u_button_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (ped_button),
    .rise     (w_rise)
  );

  assign w_sem_red   = (sem_state == SEM_RED);
  assign w_red_entry = w_sem_red && (r_sem_prev != SEM_RED);
  assign w_override  = !sem_is_active(sem_state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= PED_DARK;
      r_cnt      <= '0;
      r_blink    <= 1'b0;
      r_req      <= 1'b0;
      r_sem_prev <= SEM_OFF;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_blink    <= w_blink_nxt;
      r_req      <= w_req_nxt;
      r_sem_prev <= sem_state;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_blink_nxt = r_blink;
    w_grant     = 1'b0;
    if (w_override) begin
      w_state_nxt = PED_DARK;
      w_cnt_nxt   = '0;
      w_blink_nxt = 1'b0;
    end else begin
      unique case (r_state)
        PED_DARK: w_state_nxt = PED_DONT_WALK;
        PED_DONT_WALK: begin
          // A rise in the same cycle as red entry still counts as a request.
          if (w_red_entry && (r_req || w_rise)) begin
            w_state_nxt = PED_WALK;
            w_cnt_nxt   = WALK_LOAD;
            w_grant     = 1'b1;
          end
        end
        PED_WALK: begin
          if (!w_sem_red) begin
            w_state_nxt = PED_DONT_WALK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == '0) begin
            w_state_nxt = PED_FLASH;
            w_cnt_nxt   = FLASH_LOAD;
            w_blink_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        PED_FLASH: begin
          if (!w_sem_red || (r_cnt == '0)) begin
            w_state_nxt = PED_DONT_WALK;
            w_cnt_nxt   = '0;
            w_blink_nxt = 1'b0;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_ONE;
            w_blink_nxt = ~r_blink;
          end
        end
        default: begin
          w_state_nxt = PED_DARK;
          w_cnt_nxt   = '0;
          w_blink_nxt = 1'b0;
        end
      endcase
    end

    // Clearing on grant or override wins over a coincident button rise.
    if (w_override || w_grant) begin
      w_req_nxt = 1'b0;
    end else if (w_rise) begin
      w_req_nxt = 1'b1;
    end else begin
      w_req_nxt = r_req;
    end
  end

  always_comb begin
    walk      = 1'b0;
    dont_walk = 1'b0;
    countdown = '0;
    unique case (r_state)
      PED_DONT_WALK: dont_walk = 1'b1;
      PED_WALK: begin
        walk      = 1'b1;
        countdown = r_cnt;
      end
      PED_FLASH: begin
        dont_walk = r_blink;
        countdown = r_cnt;
      end
      default: ;
    endcase
  end

  assign req_pending = r_req;
  assign ped_state   = r_state;

endmodule

// File: tb/tb_pedestrian_signal_ctrl.sv
// Self-checking bench for pedestrian_signal_ctrl: directed scenarios plus a
// randomized run, compared against a phase-age reference model.
module tb_pedestrian_signal_ctrl;

  localparam int W = 8;
  localparam int F = 6;
  localparam logic [3:0] S_OFF = 4'b0001;
  localparam logic [3:0] S_RED = 4'b0010;
  localparam logic [3:0] S_YEL = 4'b0100;
  localparam logic [3:0] S_GRN = 4'b1000;

  logic       clk;
  logic       reset_n;
  logic [3:0] sem_state;
  logic       ped_button;
  logic       walk;
  logic       dont_walk;
  logic [4:0] countdown;
  logic       req_pending;
  logic [3:0] ped_state;

  int checks;
  int errors;

  // Reference model: dark flag, age within the walk+flash phase (-1 = idle),
  // latched request, previous semaphore code and button sample history.
  bit         m_dark;
  int         m_age;
  bit         m_req;
  logic [3:0] m_prev;
  bit   [2:0] m_hist;

  pedestrian_signal_ctrl #(
    .WALK_CYCLES  (W),
    .FLASH_CYCLES (F),
    .CNT_W        (5)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sem_state   (sem_state),
    .ped_button  (ped_button),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .req_pending (req_pending),
    .ped_state   (ped_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_dark = 1'b1;
    m_age  = -1;
    m_req  = 1'b0;
    m_prev = S_OFF;
    m_hist = '0;
  endtask

  task automatic model_step(input logic [3:0] s, input logic b);
    bit pressed;
    bit valid;
    bit red_entry;
    pressed   = m_hist[1] && !m_hist[2];
    valid     = (s == S_RED) || (s == S_YEL) || (s == S_GRN);
    red_entry = (s == S_RED) && (m_prev != S_RED);
    if (!valid) begin
      m_dark = 1'b1;
      m_age  = -1;
      m_req  = 1'b0;
    end else if (m_dark) begin
      m_dark = 1'b0;
      if (pressed) m_req = 1'b1;
    end else if (m_age >= 0) begin
      if (s != S_RED) m_age = -1;
      else begin
        m_age = m_age + 1;
        if (m_age >= W + F) m_age = -1;
      end
      if (pressed) m_req = 1'b1;
    end else if (red_entry && (m_req || pressed)) begin
      m_age = 0;
      m_req = 1'b0;
    end else if (pressed) begin
      m_req = 1'b1;
    end
    m_hist = {m_hist[1], m_hist[0], b};
    m_prev = s;
  endtask

  function automatic logic [11:0] exp_vec();
    logic [3:0] st;
    logic       w;
    logic       d;
    int         c;
    int         f;
    w = 1'b0; d = 1'b0; c = 0;
    if (m_dark) st = 4'b0001;
    else if (m_age < 0) begin
      st = 4'b0010; d = 1'b1;
    end else if (m_age < W) begin
      st = 4'b0100; w = 1'b1; c = W - 1 - m_age;
    end else begin
      f  = m_age - W;
      st = 4'b1000; d = ((f % 2) == 0); c = F - 1 - f;
    end
    return {st, w, d, c[4:0], m_req};
  endfunction

  task automatic tick(input logic [3:0] s, input logic b);
    sem_state  = s;
    ped_button = b;
    @(posedge clk);
    model_step(s, b);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    reset_n = 1'b1; sem_state = S_OFF; ped_button = 1'b0;
    #1 reset_n = 1'b0;
    model_reset();
    #2;
    got = {ped_state, walk, dont_walk, countdown, req_pending};
    checks++;
    if (got !== exp_vec()) begin
      errors++; $display("FAIL reset_por: got %h required %h", got, exp_vec());
    end
    @(posedge clk); #1 reset_n = 1'b1;
    tick(S_GRN, 1'b1);
    repeat (3) tick(S_GRN, 1'b0);
    repeat (2) tick(S_RED, 1'b0);
    checks++;
    if (ped_state !== 4'b0100) begin
      errors++; $display("FAIL reset_prewalk: got %b required %b", ped_state, 4'b0100);
    end
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    got = {ped_state, walk, dont_walk, countdown, req_pending};
    checks++;
    if (got !== 12'h100) begin
      errors++; $display("FAIL reset_async: got %h required %h", got, 12'h100);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    tick(S_GRN, 1'b0);
    got = {ped_state, walk, dont_walk, countdown, req_pending};
    checks++;
    if (got !== exp_vec() || ped_state !== 4'b0010) begin
      errors++; $display("FAIL reset_release: got %h required %h", got, exp_vec());
    end
  endtask

  task automatic test_basic_grant();
    logic [11:0] got;
    logic [5:0]  pat;
    int          nwalk;
    int          nflash;
    pat = '0; nwalk = 0; nflash = 0;
    tick(S_GRN, 1'b1);
    tick(S_GRN, 1'b0);
    checks++;
    if (req_pending !== 1'b0) begin
      errors++; $display("FAIL grant_req_early: got %b required 0", req_pending);
    end
    tick(S_GRN, 1'b0);
    checks++;
    if (req_pending !== 1'b1) begin
      errors++; $display("FAIL grant_req_edge3: got %b required 1", req_pending);
    end
    for (int i = 0; i < 20; i++) begin
      tick(S_RED, 1'b0);
      got = {ped_state, walk, dont_walk, countdown, req_pending};
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL grant_cycle%0d: got %h required %h", i, got, exp_vec());
      end
      if (walk) nwalk++;
      if (ped_state == 4'b1000) begin
        pat = {pat[4:0], dont_walk};
        nflash++;
      end
    end
    checks++;
    if (nwalk != W || nflash != F) begin
      errors++; $display("FAIL grant_durations: got walk=%0d flash=%0d required %0d/%0d", nwalk, nflash, W, F);
    end
    checks++;
    if (pat !== 6'b101010) begin
      errors++; $display("FAIL grant_blink: got %b required 101010", pat);
    end
    checks++;
    if (dont_walk !== 1'b1 || req_pending !== 1'b0) begin
      errors++; $display("FAIL grant_end: got dw=%b req=%b required 1/0", dont_walk, req_pending);
    end
  endtask

  task automatic test_no_request();
    logic [11:0] got;
    int          nwalk;
    int          nflash;
    nwalk = 0; nflash = 0;
    repeat (2) tick(S_GRN, 1'b0);
    repeat (5) begin
      tick(S_RED, 1'b0);
      if (walk) nwalk++;
    end
    tick(S_RED, 1'b1);
    repeat (5) begin
      tick(S_RED, 1'b0);
      if (walk) nwalk++;
    end
    checks++;
    if (nwalk != 0 || req_pending !== 1'b1) begin
      errors++; $display("FAIL noreq_hold: got walk=%0d req=%b required 0/1", nwalk, req_pending);
    end
    repeat (2) tick(S_GRN, 1'b0);
    repeat (2) tick(S_YEL, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick(S_RED, 1'b0);
      got = {ped_state, walk, dont_walk, countdown, req_pending};
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL noreq_cycle%0d: got %h required %h", i, got, exp_vec());
      end
      if (walk) nwalk++;
      if (ped_state == 4'b1000) nflash++;
    end
    checks++;
    if (nwalk != W || nflash != F) begin
      errors++; $display("FAIL noreq_next_red: got walk=%0d flash=%0d required %0d/%0d", nwalk, nflash, W, F);
    end
  endtask

  task automatic test_abort();
    logic [11:0] got;
    int          nflash;
    nflash = 0;
    tick(S_GRN, 1'b1);
    repeat (3) tick(S_GRN, 1'b0);
    repeat (3) begin
      tick(S_RED, 1'b0);
      got = {ped_state, walk, dont_walk, countdown, req_pending};
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL abort_walk: got %h required %h", got, exp_vec());
      end
    end
    tick(S_GRN, 1'b0);
    got = {ped_state, walk, dont_walk, countdown, req_pending};
    checks++;
    if (ped_state !== 4'b0010 || walk !== 1'b0 || countdown !== 5'd0 || got !== exp_vec()) begin
      errors++; $display("FAIL abort_exit: got %h required %h", got, exp_vec());
    end
    repeat (10) begin
      tick(S_GRN, 1'b0);
      if (ped_state == 4'b1000) nflash++;
    end
    checks++;
    if (nflash != 0) begin
      errors++; $display("FAIL abort_noflash: got %0d flash cycles required 0", nflash);
    end
  endtask

  task automatic test_off_illegal();
    logic [3:0]  codes [2];
    logic [11:0] got;
    codes[0] = 4'b0001;
    codes[1] = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      repeat (2) tick(S_GRN, 1'b0);
      tick(S_GRN, 1'b1);
      repeat (3) tick(S_GRN, 1'b0);
      repeat (9) tick(S_RED, 1'b0);
      tick(S_RED, 1'b1);
      repeat (2) tick(S_RED, 1'b0);
      got = {ped_state, walk, dont_walk, countdown, req_pending};
      checks++;
      if (got !== exp_vec() || ped_state !== 4'b1000 || req_pending !== 1'b1) begin
        errors++; $display("FAIL illegal_pre%0d: got %h required %h", k, got, exp_vec());
      end
      tick(codes[k], 1'b0);
      got = {ped_state, walk, dont_walk, countdown, req_pending};
      checks++;
      if (got !== 12'h100) begin
        errors++; $display("FAIL illegal_dark%0d: got %h required %h", k, got, 12'h100);
      end
      tick(S_GRN, 1'b0);
      got = {ped_state, walk, dont_walk, countdown, req_pending};
      checks++;
      if (got !== exp_vec() || ped_state !== 4'b0010) begin
        errors++; $display("FAIL illegal_recover%0d: got %h required %h", k, got, exp_vec());
      end
    end
  endtask

  task automatic test_held_button();
    logic [11:0] got;
    logic [3:0]  prev_ps;
    int          grants;
    grants = 0;
    repeat (30) tick(S_GRN, 1'b1);
    tick(S_GRN, 1'b0);
    prev_ps = ped_state;
    for (int i = 0; i < 20; i++) begin
      tick(S_RED, (i == 4 || i == 5));
      got = {ped_state, walk, dont_walk, countdown, req_pending};
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL held_cycle%0d: got %h required %h", i, got, exp_vec());
      end
      if (ped_state == 4'b0100 && prev_ps != 4'b0100) grants++;
      prev_ps = ped_state;
    end
    checks++;
    if (grants != 1 || req_pending !== 1'b1) begin
      errors++; $display("FAIL held_first_red: got grants=%0d req=%b required 1/1", grants, req_pending);
    end
    grants = 0;
    repeat (2) tick(S_GRN, 1'b0);
    repeat (2) tick(S_YEL, 1'b0);
    prev_ps = ped_state;
    repeat (18) begin
      tick(S_RED, 1'b0);
      if (ped_state == 4'b0100 && prev_ps != 4'b0100) grants++;
      prev_ps = ped_state;
    end
    checks++;
    if (grants != 1 || req_pending !== 1'b0) begin
      errors++; $display("FAIL held_second_red: got grants=%0d req=%b required 1/0", grants, req_pending);
    end
  endtask

  task automatic test_random();
    logic [11:0] got;
    logic [3:0]  cur;
    logic        btn;
    int unsigned lim;
    int unsigned r;
    cur = S_GRN;
    btn = 1'b0;
    for (int i = 0; i < 800; i++) begin
      lim = (cur == S_RED) ? 24 : 8;
      if ($urandom_range(lim - 1, 0) == 0) begin
        r = $urandom_range(19, 0);
        if (r == 0) cur = S_OFF;
        else if (r == 1) cur = 4'($urandom);
        else begin
          case (cur)
            S_GRN:   cur = S_YEL;
            S_YEL:   cur = S_RED;
            S_RED:   cur = S_GRN;
            default: cur = S_GRN;
          endcase
        end
      end
      if ($urandom_range(5, 0) == 0) btn = ~btn;
      tick(cur, btn);
      got = {ped_state, walk, dont_walk, countdown, req_pending};
      checks++;
      if (got !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: sem=%b got %h required %h", i, cur, got, exp_vec());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_grant();
    test_no_request();
    test_abort();
    test_off_illegal();
    test_held_button();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
